// File: rtl/rsp_encode.sv
// Read-response framer: header byte, then BYTE_NUM rfifo bytes, out to uart_tx.
// Optional trailing checksum byte when RSP_CHKSUM_EN is defined.
module rsp_encode #(
  parameter int unsigned BYTE_NUM = 8,
  parameter logic [7:0]  RSP_HDR  = 8'hAA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_start,
  input  logic       rfifo_empty,
  input  logic [7:0] rfifo_data,
  output logic       rfifo_rd_en,
  input  logic       uart_tx_busy,
  output logic       uart_tx_vld,
  output logic [7:0] uart_tx_data,
  output logic       busy
);

  localparam logic [7:0] LAST_CNT = 8'(BYTE_NUM);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_TXW, S_CHK, S_POP, S_LAT, S_SEND
`ifdef RSP_CHKSUM_EN
    , S_SUM
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       guard_q, guard_d;
  logic       rd_en_q, rd_en_d;
  logic       vld_q, vld_d;
  logic [7:0] data_q, data_d;
  logic       busy_q, busy_d;
`ifdef RSP_CHKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       sum_sent_q, sum_sent_d;
`endif

  // Strobes are computed one state ahead so that the registered rd_en/vld
  // line up with the POP and SEND cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    guard_d = 1'b0;
    rd_en_d = 1'b0;
    vld_d   = 1'b0;
    data_d  = data_q;
`ifdef RSP_CHKSUM_EN
    sum_d      = sum_q;
    sum_sent_d = sum_sent_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          state_d = S_HDR;
          cnt_d   = '0;
`ifdef RSP_CHKSUM_EN
          sum_d      = '0;
          sum_sent_d = 1'b0;
`endif
        end
      end
      S_HDR: begin
        if (!uart_tx_busy) begin
          vld_d   = 1'b1;
          data_d  = RSP_HDR;
          guard_d = 1'b1;
          state_d = S_TXW;
        end
      end
      S_TXW: begin
        // Guard cycle lets the transmitter raise busy for the byte just strobed.
        if (!guard_q && !uart_tx_busy) begin
`ifdef RSP_CHKSUM_EN
          state_d = sum_sent_q ? S_IDLE : S_CHK;
`else
          state_d = S_CHK;
`endif
        end
      end
      S_CHK: begin
        if (cnt_q == LAST_CNT) begin
`ifdef RSP_CHKSUM_EN
          state_d = S_SUM;
`else
          state_d = S_IDLE;
`endif
        end else if (!rfifo_empty) begin
          rd_en_d = 1'b1;
          state_d = S_POP;
        end
      end
      S_POP: state_d = S_LAT;
      S_LAT: begin
        data_d  = rfifo_data;
        cnt_d   = cnt_q + 8'd1;
        vld_d   = 1'b1;
`ifdef RSP_CHKSUM_EN
        sum_d   = sum_q + rfifo_data;
`endif
        state_d = S_SEND;
      end
      S_SEND: begin
        guard_d = 1'b1;
        state_d = S_TXW;
      end
`ifdef RSP_CHKSUM_EN
      S_SUM: begin
        if (!uart_tx_busy) begin
          vld_d      = 1'b1;
          data_d     = sum_q;
          sum_sent_d = 1'b1;
          guard_d    = 1'b1;
          state_d    = S_TXW;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      guard_q <= 1'b0;
      rd_en_q <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
`ifdef RSP_CHKSUM_EN
      sum_q      <= '0;
      sum_sent_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      guard_q <= guard_d;
      rd_en_q <= rd_en_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
`ifdef RSP_CHKSUM_EN
      sum_q      <= sum_d;
      sum_sent_q <= sum_sent_d;
`endif
    end
  end

  assign rfifo_rd_en  = rd_en_q;
  assign uart_tx_vld  = vld_q;
  assign uart_tx_data = data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rsp_encode.sv
// Scoreboard bench for rsp_encode: expected frames queued at rd_start, checked per uart strobe.
module tb_rsp_encode;
  localparam int unsigned BN  = 8;
  localparam logic [7:0]  HDR = 8'hAA;
`ifdef RSP_CHKSUM_EN
  localparam int FLEN = BN + 2;
`else
  localparam int FLEN = BN + 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_start = 1'b0;
  logic       rfifo_empty;
  logic [7:0] rfifo_data = 8'h00;
  logic       rfifo_rd_en;
  logic       uart_tx_busy;
  logic       uart_tx_vld;
  logic [7:0] uart_tx_data;
  logic       busy;

  always #5 clk = ~clk;

  rsp_encode #(.BYTE_NUM(BN), .RSP_HDR(HDR)) dut (
    .clk(clk), .rst(rst), .rd_start(rd_start),
    .rfifo_empty(rfifo_empty), .rfifo_data(rfifo_data), .rfifo_rd_en(rfifo_rd_en),
    .uart_tx_busy(uart_tx_busy), .uart_tx_vld(uart_tx_vld), .uart_tx_data(uart_tx_data),
    .busy(busy)
  );

  // rfifo model: registered read data one cycle after the pop strobe
  logic       push_en = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] fifo_mem[$];
  int         fifo_cnt = 0;
  always @(posedge clk) begin
    if (rfifo_rd_en && fifo_mem.size() != 0) rfifo_data <= fifo_mem.pop_front();
    if (push_en) fifo_mem.push_back(push_data);
    fifo_cnt <= fifo_cnt + (push_en ? 1 : 0) - ((rfifo_rd_en && fifo_cnt != 0) ? 1 : 0);
  end
  assign rfifo_empty = (fifo_cnt == 0);

  // uart_tx model: busy from the cycle after a strobe for tx_hold cycles
  int unsigned tx_hold = 3;
  int unsigned busy_cnt = 0;
  always @(posedge clk) begin
    if (uart_tx_vld)        busy_cnt <= tx_hold;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_tx_busy = (busy_cnt != 0);

  int checks = 0;
  int errors = 0;
  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  logic [7:0] exp_arr[0:1023];
  int         wr_idx = 0;
  int         n_vld  = 0;
  int         n_pop  = 0;

  // Monitor: pops the expected stream on every uart strobe
  initial begin
    forever begin
      @(negedge clk);
      if (rfifo_rd_en) begin
        n_pop++;
        check("pop_when_empty", int'(rfifo_empty), 0);
      end
      if (uart_tx_vld) begin
        check("vld_while_tx_busy", int'(uart_tx_busy), 0);
        if (n_vld < wr_idx) check("tx_byte", int'(uart_tx_data), int'(exp_arr[n_vld]));
        else check("unexpected_strobe", n_vld, wr_idx - 1);
        n_vld++;
      end
    end
  end

  // Reference: bytes the rfifo will deliver, in order; a frame is header + next BN + sum
  logic [7:0] ref_stream[$];

  task automatic fifo_push(input logic [7:0] b);
    @(negedge clk);
    push_en = 1'b1;
    push_data = b;
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic load(input logic [7:0] b);
    ref_stream.push_back(b);
    fifo_push(b);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
  endtask

  task automatic start_frame(output int base, output int pops0);
    logic [7:0] sum;
    sum = 8'h00;
    base = wr_idx;
    pops0 = n_pop;
    exp_arr[wr_idx] = HDR;
    wr_idx++;
    for (int i = 0; i < int'(BN); i++) begin
      exp_arr[wr_idx] = ref_stream[i];
      wr_idx++;
      sum = sum + ref_stream[i];
    end
`ifdef RSP_CHKSUM_EN
    exp_arr[wr_idx] = sum;
    wr_idx++;
`endif
    pulse_start();
    check("busy_rise", int'(busy), 1);
  endtask

  task automatic wait_strobes(input int target, input string name);
    int budget;
    budget = FLEN * (int'(tx_hold) + 12) + 400;
    for (int c = 0; c < budget && n_vld < target; c++) @(negedge clk);
    check(name, int'(n_vld >= target), 1);
  endtask

  task automatic end_frame(input int base, input int pops0);
    int budget;
    budget = FLEN * (int'(tx_hold) + 12) + 400;
    for (int c = 0; c < budget && !(n_vld >= base + FLEN && !busy); c++) @(negedge clk);
    check("frame_done", int'(!busy), 1);
    repeat (30) @(negedge clk);
    check("frame_strobes", n_vld - base, FLEN);
    check("frame_pops", n_pop - pops0, int'(BN));
    check("busy_idle", int'(busy), 0);
    for (int i = 0; i < int'(BN); i++) void'(ref_stream.pop_front());
  endtask

  initial begin
    int base, pops0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", int'(rfifo_rd_en), 0);
    check("rst_vld", int'(uart_tx_vld), 0);
    check("rst_data", int'(uart_tx_data), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // preloaded 01..08
    for (int i = 1; i <= 8; i++) load(8'(i));
    start_frame(base, pops0);
    end_frame(base, pops0);

    // fifo empty at start, data arrives 50 cycles later
    for (int i = 0; i < 8; i++) ref_stream.push_back(8'(8'h10 + i));
    start_frame(base, pops0);
    repeat (50) @(negedge clk);
    check("hdr_before_data", n_vld - base, 1);
    check("wait_busy", int'(busy), 1);
    for (int i = 0; i < 8; i++) fifo_push(8'(8'h10 + i));
    end_frame(base, pops0);

    // long transmitter busy time
    tx_hold = 200;
    for (int i = 0; i < 8; i++) load(8'($urandom));
    start_frame(base, pops0);
    end_frame(base, pops0);
    tx_hold = 3;

    // second rd_start mid-frame is ignored
    for (int i = 0; i < 8; i++) load(8'($urandom));
    start_frame(base, pops0);
    wait_strobes(base + 3, "mid_frame_progress");
    pulse_start();
    end_frame(base, pops0);

    // checksum wrap case
    load(8'hFF); load(8'hFF); load(8'h01);
    for (int i = 0; i < 5; i++) load(8'h00);
    start_frame(base, pops0);
    end_frame(base, pops0);

    // reset after the 3rd data byte
    tx_hold = 6;
    for (int i = 1; i <= 11; i++) load(8'(i));
    start_frame(base, pops0);
    wait_strobes(base + 4, "pre_reset_progress");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rd_en", int'(rfifo_rd_en), 0);
    check("mid_rst_vld", int'(uart_tx_vld), 0);
    check("mid_rst_data", int'(uart_tx_data), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_pops", n_pop - pops0, 3);
    wr_idx = n_vld;
    for (int i = 0; i < 3; i++) void'(ref_stream.pop_front());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_frame(base, pops0);
    end_frame(base, pops0);

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      tx_hold = $urandom_range(1, 10);
      while (ref_stream.size() < int'(BN)) load(8'($urandom));
      start_frame(base, pops0);
      end_frame(base, pops0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
